// File: rtl/heartbeat_watchdog_if.sv
// heartbeat_watchdog_if
// Groups the watchdog's configuration, heartbeat input and status outputs.
//   cfg               : [0] enable, [1] clear (rising edge), [2] action enable
//   heartbeat_in      : asynchronous heartbeat from the peer board
//   instant_reset_req : latched fault request toward the reset manager
//   fault_sts         : 32-bit status word for the PS
// The master modport belongs to whoever drives cfg and the heartbeat.
// The slave modport belongs to the watchdog itself.
interface heartbeat_watchdog_if;
  logic [7:0]  cfg;
  logic        heartbeat_in;
  logic        instant_reset_req;
  logic [31:0] fault_sts;

  modport master (
    output cfg,
    output heartbeat_in,
    input  instant_reset_req,
    input  fault_sts
  );

  modport slave (
    input  cfg,
    input  heartbeat_in,
    output instant_reset_req,
    output fault_sts
  );
endinterface

// File: rtl/heartbeat_watchdog.sv
// heartbeat_watchdog
// Watches the alive heartbeat from a peer board (nominally 100 ms low and
// 10 ms high). When the heartbeat is missing, it raises a latched instant
// reset request toward the board reset manager.
// A high pulse counts as a valid beat only if it is long enough. Shorter
// pulses are counted as glitches and otherwise ignored.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : heartbeat_watchdog_if.slave
//           - in:  cfg, heartbeat_in
//           - out: instant_reset_req, fault_sts
// fault_sts layout:
//   [1:0]   state
//   [2]     synchronised heartbeat
//   [3]     request
//   [7:4]   glitch count
//   [15:8]  beat count
//   [23:16] fault count
//   [31:24] zero
module heartbeat_watchdog #(
  parameter int TIMEOUT_CYCLES  = 13750000,
  parameter int MIN_HIGH_CYCLES = 625000,
  parameter int SYNC_STAGES     = 2
) (
  input logic               clk,
  input logic               reset,
  heartbeat_watchdog_if.slave bus
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMING   = 2'd1,
    MONITOR  = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES);
  localparam int HI_W  = $clog2(MIN_HIGH_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HI_W-1:0]  HI_MAX   = HI_W'(MIN_HIGH_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hb_s;
  logic                   hb_d;
  logic                   rise;
  logic                   fall;
  logic                   valid_beat;
  logic [HI_W-1:0]        hi_cnt;
  logic                   clr_d;
  logic                   clr_edge;
  logic                   enable;
  logic                   action;
  state_t                 state;
  state_t                 state_next;
  logic [GAP_W-1:0]       gap_cnt;
  logic [GAP_W-1:0]       gap_next;
  logic                   req;
  logic                   req_next;
  logic                   fault_inc;
  logic [3:0]             glitch_cnt;
  logic [7:0]             beat_cnt;
  logic [7:0]             fault_cnt;
  logic                   unused_cfg;

  assign enable     = bus.cfg[0];
  assign action     = bus.cfg[2];
  assign unused_cfg = ^bus.cfg[7:3];

  assign hb_s       = sync_q[SYNC_STAGES-1];
  assign rise       = hb_s & ~hb_d;
  assign fall       = ~hb_s & hb_d;
  // hi_cnt saturates at HI_MAX, so a pulse of at least the minimum length
  // is still recognised when it finally falls.
  assign valid_beat = fall && (hi_cnt >= HI_MAX);
  assign clr_edge   = bus.cfg[1] & ~clr_d;

  // Synchroniser chain, the delayed copy used for edge detection,
  // and the registered edge detect on the clear bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hb_d   <= 1'b0;
      clr_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.heartbeat_in};
      hb_d   <= hb_s;
      clr_d  <= bus.cfg[1];
    end
  end

  // Pulse-width measurement and the diagnostic counters. The glitch and
  // fault counters saturate so that a long-running fault stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_cnt     <= '0;
      glitch_cnt <= '0;
      beat_cnt   <= '0;
      fault_cnt  <= '0;
    end else begin
      if (rise) begin
        hi_cnt <= '0;
      end else if (hb_s && (hi_cnt != HI_MAX)) begin
        hi_cnt <= hi_cnt + HI_W'(1);
      end
      if (fall && !valid_beat && (glitch_cnt != 4'hF)) begin
        glitch_cnt <= glitch_cnt + 4'd1;
      end
      if (valid_beat && (state != DISABLED)) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (fault_inc && (fault_cnt != 8'hFF)) begin
        fault_cnt <= fault_cnt + 8'd1;
      end
    end
  end

  // State, gap counter and the registered request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DISABLED;
      gap_cnt <= '0;
      req     <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
      req     <= req_next;
    end
  end

  // Next-state logic. Dropping enable overrides everything else.
  // In MONITOR, a beat arriving on the final gap cycle still wins over
  // the timeout.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    req_next   = req;
    fault_inc  = 1'b0;
    if (!enable) begin
      state_next = DISABLED;
      gap_next   = '0;
      req_next   = 1'b0;
    end else begin
      case (state)
        DISABLED: begin
          state_next = ARMING;
          gap_next   = '0;
          req_next   = 1'b0;
        end
        ARMING: begin
          gap_next = '0;
          req_next = 1'b0;
          if (valid_beat) begin
            state_next = MONITOR;
          end
        end
        MONITOR: begin
          if (valid_beat) begin
            gap_next = '0;
          end else if (gap_cnt == GAP_LAST) begin
            state_next = FAULT;
            gap_next   = '0;
            req_next   = action;
            fault_inc  = 1'b1;
          end else begin
            gap_next = gap_cnt + GAP_W'(1);
          end
        end
        FAULT: begin
          gap_next = '0;
          req_next = action;
          if (clr_edge) begin
            state_next = ARMING;
            req_next   = 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.instant_reset_req = req;
  assign bus.fault_sts = {8'h00, fault_cnt, beat_cnt, glitch_cnt, req, hb_s, state};

endmodule
